// File: rtl/demux1x8_sec.sv
// Rebuilds 8 parallel registered lanes from a time-multiplexed word stream,
// in addressed (S) or auto-scan mode, with a frame-complete handshake.
module demux1x8_sec #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   D,
    input  logic [2:0]         S,
    input  logic               valid_in,
    input  logic               mode,
    input  logic               clear,
    input  logic               frame_ack,
    output logic               ready,
    output logic [8*WIDTH-1:0] Y,
    output logic [7:0]         lane_valid,
    output logic [2:0]         scan_idx,
    output logic               frame_done,
    output logic               overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic       accept;
    logic [2:0] target;
    logic [7:0] lane_next;

    // ready depends on registered state only, so no input reaches an output
    assign ready     = (state != DONE);
    assign accept    = valid_in & ready & ~clear;
    assign target    = mode ? scan_idx : S;
    assign lane_next = lane_valid | (8'b1 << target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            Y          <= '0;
            lane_valid <= '0;
            scan_idx   <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            Y          <= '0;
            lane_valid <= '0;
            scan_idx   <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (valid_in && !ready)
                overrun <= 1'b1;
            if (state == DONE) begin
                // Y is deliberately kept; only the written flags are dropped
                if (frame_ack) begin
                    state      <= IDLE;
                    lane_valid <= '0;
                    scan_idx   <= '0;
                end
            end else if (accept) begin
                Y[target*WIDTH +: WIDTH] <= D;
                lane_valid               <= lane_next;
                if (mode)
                    scan_idx <= scan_idx + 3'd1;
                if (lane_next == 8'hFF) begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                end else begin
                    state <= FILL;
                end
            end
        end
    end

endmodule
